// File: rtl/memory_interface_unit.sv
// Byte-addressable, big-endian memory with an MOV/MOC handshake and a fixed access latency.
// Accesses that are misaligned or use the reserved size complete with AlignErr set and do not touch memory.
module memory_interface_unit #(
  parameter int LATENCY     = 2,
  parameter int DEPTH_BYTES = 512
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  typeData,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        AlignErr,
  output logic        Busy
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          rw_q;
  logic [1:0]    td_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   din_q;
  logic [31:0]   dout_q;
  logic          moc_q, err_q, busy_q;

  logic [7:0]    mem [DEPTH_BYTES];

  // Upper address bits only select an alias of the same storage.
  logic unused_addr;
  assign unused_addr = ^Address[31:AW];

  logic [AW-1:0] a1, a2, a3;
  assign a1 = addr_q + AW'(1);
  assign a2 = addr_q + AW'(2);
  assign a3 = addr_q + AW'(3);

  logic mis, fire;
  logic [31:0] rdata;

  always_comb begin
    mis = (td_q == 2'b11) ||
          (td_q == 2'b10 && addr_q[0]) ||
          (td_q == 2'b00 && addr_q[1:0] != 2'b00);
    fire = (state_q == WAIT) && MOV && (cnt_q == 4'd0);
    rdata = {mem[addr_q], mem[a1], mem[a2], mem[a3]};
    case (td_q)
      2'b01:   rdata = {24'h0, mem[addr_q]};
      2'b10:   rdata = {16'h0, mem[addr_q], mem[a1]};
      default: ;
    endcase
  end

  // Storage has no reset; an async reset forces IDLE, so fire cannot be set during reset.
  always_ff @(posedge CLK) begin
    if (fire && !rw_q && !mis) begin
      case (td_q)
        2'b01: mem[addr_q] <= din_q[7:0];
        2'b10: begin
          mem[addr_q] <= din_q[15:8];
          mem[a1]     <= din_q[7:0];
        end
        default: begin
          mem[addr_q] <= din_q[31:24];
          mem[a1]     <= din_q[23:16];
          mem[a2]     <= din_q[15:8];
          mem[a3]     <= din_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      td_q    <= 2'b00;
      addr_q  <= '0;
      din_q   <= 32'h0;
      dout_q  <= 32'h0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (MOV) begin
          rw_q    <= RW;
          td_q    <= typeData;
          addr_q  <= Address[AW-1:0];
          din_q   <= DataIn;
          cnt_q   <= 4'(LATENCY - 1);
          state_q <= WAIT;
          busy_q  <= 1'b1;
        end
        WAIT: begin
          if (!MOV) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            state_q <= DONE;
            moc_q   <= 1'b1;
            err_q   <= mis;
            if (mis)       dout_q <= 32'h0;
            else if (rw_q) dout_q <= rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: if (!MOV) begin
          state_q <= IDLE;
          moc_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          moc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut  = dout_q;
  assign MOC      = moc_q;
  assign AlignErr = err_q;
  assign Busy     = busy_q;
endmodule

// File: doc/memory_interface_unit.md
MEMORY_INTERFACE_UNIT -- requirements
Module: memory_interface_unit

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning the number of clock edges from MOV sampled to MOC asserted (legal range 1-15).
REQ-002 SHALL have parameter DEPTH_BYTES, default 512, meaning the byte-addressable storage size (power of two).
REQ-003 SHALL have port CLK  input  1  single system clock, rising-edge active.
REQ-004 SHALL have port CLR  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port MOV  input  1  memory operation valid from the control unit, held high until MOC is seen.
REQ-006 SHALL have port RW  input  1  1 = read, 0 = write.
REQ-007 SHALL have port typeData  input  2  access size: 00 word, 01 byte, 10 halfword, 11 reserved.
REQ-008 SHALL have port Address  input  32  byte address from MAR.
REQ-009 SHALL have port DataIn  input  32  write data from MDR, right-aligned.
REQ-010 SHALL have port DataOut  output  32  read data, right-aligned, zero-extended.
REQ-011 SHALL have port MOC  output  1  memory operation complete.
REQ-012 SHALL have port AlignErr  output  1  misaligned or reserved-size access flag, valid with MOC.
REQ-013 SHALL have port Busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT and DONE.
REQ-015 SHALL, in IDLE with MOV=1 at a rising edge, latch Address, RW, typeData and DataIn, load the counter with LATENCY-1, and enter WAIT.
REQ-016 SHALL, in WAIT, decrement the counter each edge and, at the edge where the counter equals 0, perform the access and enter DONE.
REQ-017 SHALL therefore raise MOC exactly LATENCY edges after the edge that sampled MOV.
REQ-018 SHALL hold MOC=1, DataOut and AlignErr stable in DONE while MOV=1, and return to IDLE with MOC=0 on the first edge that samples MOV=0.
REQ-019 SHALL abort without writing memory and return to IDLE if MOV is sampled 0 while in WAIT.
REQ-020 SHALL use big-endian byte order: word at A reads bytes A, A+1, A+2, A+3 into bits [31:24] .. [7:0].
REQ-021 SHALL store a byte write from DataIn[7:0], a halfword write from DataIn[15:0], and a word write from DataIn[31:0].
REQ-022 SHALL zero-extend byte and halfword reads into DataOut.
REQ-023 SHALL index memory with Address modulo DEPTH_BYTES, so upper address bits are ignored and access wraps around.
REQ-024 SHALL flag AlignErr=1 for a halfword access with Address[0]=1, a word access with Address[1:0]!=00, or typeData=11.
REQ-025 SHALL, on an AlignErr access, suppress the memory write, drive DataOut=0, and still complete the handshake with MOC.
REQ-026 SHALL leave DataOut unchanged after a write completes, holding the last read value.
REQ-027 SHALL ignore changes on Address, RW, typeData and DataIn after the latching edge until the next IDLE acceptance.

Reset
REQ-028 SHALL, while CLR=0, force the state to IDLE, the counter to 0, and MOC=0, AlignErr=0, Busy=0, DataOut=32'h00000000, independent of CLK.
REQ-029 SHALL, on reset mid-operation (WAIT or DONE), discard the pending access with no memory write.
REQ-030 SHALL leave memory contents unchanged by reset; contents are undefined until written.
REQ-031 SHALL sample MOV no earlier than the first rising edge after CLR deasserts.

Verification
REQ-032 SHALL be covered by: word write 32'hE2010000 to 0x10, then word read of 0x10 -> DataOut=32'hE2010000, MOC high 2 edges after MOV sampled, AlignErr=0.
REQ-033 SHALL be covered by: byte write 8'hAB to 0x13 after the above, then word read of 0x10 -> 32'hE20100AB; byte read of 0x10 -> 32'h000000E2.
REQ-034 SHALL be covered by: halfword read at 0x11 and typeData=11 -> MOC asserted, AlignErr=1, DataOut=0, memory unchanged on a re-read of word 0x10.
REQ-035 SHALL be covered by: word write 32'h12345678 to 0x00000200 -> word read of 0x00000000 returns 32'h12345678, demonstrating wrap-around.
REQ-036 SHALL be covered by: MOV dropped during WAIT on a write, and CLR pulsed low during WAIT on another write -> both return to IDLE, MOC=0, and the target word is unchanged.
REQ-037 SHALL be covered by: MOV held high for 5 cycles in DONE -> MOC stays 1 throughout, then falls on the first edge that samples MOV=0; a new MOV issued the next cycle is accepted.
